// File: rtl/qsys_led_master_0_bytes_to_packets_if.sv
// ----------------------------------------------------------------------------
// qsys_led_master_0_bytes_to_packets_if
// Groups the two streaming links of the bytes-to-packets decoder:
//   in_*  : escaped host byte stream (sink side of the decoder)
//   out_* : decoded Avalon-ST packet stream (source side of the decoder)
// Modports:
//   slave  : the decoder's view (accepts bytes, produces packet beats)
//   master : the surrounding system's view (supplies bytes, consumes beats)
// ----------------------------------------------------------------------------
interface qsys_led_master_0_bytes_to_packets_if #(
  parameter int CHANNEL_WIDTH = 8
);
  logic                     in_ready;
  logic                     in_valid;
  logic [7:0]               in_data;
  logic                     out_ready;
  logic                     out_valid;
  logic [7:0]               out_data;
  logic [CHANNEL_WIDTH-1:0] out_channel;
  logic                     out_startofpacket;
  logic                     out_endofpacket;

  modport slave (
    output in_ready,
    input  in_valid, in_data,
    input  out_ready,
    output out_valid, out_data, out_channel, out_startofpacket, out_endofpacket
  );

  modport master (
    input  in_ready,
    output in_valid, in_data,
    output out_ready,
    input  out_valid, out_data, out_channel, out_startofpacket, out_endofpacket
  );
endinterface

// File: rtl/qsys_led_master_0_bytes_to_packets.sv
// ----------------------------------------------------------------------------
// qsys_led_master_0_bytes_to_packets
// Decodes the escaped host byte stream into Avalon-ST packet beats carrying
// channel, SOP and EOP. Special bytes: 0x7A SOP, 0x7B EOP, 0x7C CHANNEL,
// 0x7D ESCAPE (the following byte is XORed with 0x20).
// Ports:
//   clk    : single rising-edge clock
//   reset  : asynchronous, active-high reset
//   st     : slave modport carrying in_* (byte sink) and out_* (packet source)
// Output beats are registered; one accepted payload byte appears on out_* the
// following cycle, sustaining one byte per cycle while out_ready stays high.
// ----------------------------------------------------------------------------
module qsys_led_master_0_bytes_to_packets #(
  parameter int                       CHANNEL_WIDTH = 8,
  parameter logic [CHANNEL_WIDTH-1:0] CHANNEL_RESET = '0
) (
  input logic                                clk,
  input logic                                reset,
  qsys_led_master_0_bytes_to_packets_if.slave st
);

  typedef enum logic [1:0] {
    S_DATA,
    S_ESC,
    S_CHAN,
    S_CHAN_ESC
  } state_e;

  localparam logic [7:0] B_SOP  = 8'h7A;
  localparam logic [7:0] B_EOP  = 8'h7B;
  localparam logic [7:0] B_CHAN = 8'h7C;
  localparam logic [7:0] B_ESC  = 8'h7D;
  localparam logic [7:0] ESC_XOR = 8'h20;

  state_e                   state_q, state_d;
  logic                     sop_pend_q, sop_pend_d;
  logic                     eop_pend_q, eop_pend_d;
  logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;          // latest decoded channel
  logic                     out_valid_q, out_valid_d;
  logic [7:0]               out_data_q, out_data_d;
  logic [CHANNEL_WIDTH-1:0] out_channel_q, out_channel_d;
  logic                     out_sop_q, out_sop_d;
  logic                     out_eop_q, out_eop_d;

  logic       accept;
  logic       emit;
  logic [7:0] payload;

  // Zero-extends or truncates a channel byte to CHANNEL_WIDTH.
  function automatic logic [CHANNEL_WIDTH-1:0] to_chan(input logic [7:0] b);
    logic [CHANNEL_WIDTH+7:0] wide;
    wide = {{CHANNEL_WIDTH{1'b0}}, b};
    return wide[CHANNEL_WIDTH-1:0];
  endfunction

  // The output register can take a new byte whenever it is empty or its
  // current beat is completing this cycle.
  assign st.in_ready = !out_valid_q || st.out_ready;
  assign accept      = st.in_valid && st.in_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    sop_pend_d    = sop_pend_q;
    eop_pend_d    = eop_pend_q;
    chan_d        = chan_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    emit          = 1'b0;
    payload       = st.in_data;

    if (out_valid_q && st.out_ready) out_valid_d = 1'b0;

    if (accept) begin
      unique case (state_q)
        S_DATA: begin
          unique case (st.in_data)
            B_SOP:   sop_pend_d = 1'b1;
            B_EOP:   eop_pend_d = 1'b1;
            B_CHAN:  state_d    = S_CHAN;
            B_ESC:   state_d    = S_ESC;
            default: emit       = 1'b1;
          endcase
        end
        S_ESC: begin
          emit    = 1'b1;
          payload = st.in_data ^ ESC_XOR;
          state_d = S_DATA;
        end
        S_CHAN: begin
          // Framing bytes inside a channel sequence still mark the packet.
          unique case (st.in_data)
            B_ESC:   state_d    = S_CHAN_ESC;
            B_SOP:   sop_pend_d = 1'b1;
            B_EOP:   eop_pend_d = 1'b1;
            B_CHAN:  state_d    = S_CHAN;
            default: begin
              chan_d  = to_chan(st.in_data);
              state_d = S_DATA;
            end
          endcase
        end
        S_CHAN_ESC: begin
          chan_d  = to_chan(st.in_data ^ ESC_XOR);
          state_d = S_DATA;
        end
        default: state_d = S_DATA;
      endcase
    end

    if (emit) begin
      out_valid_d   = 1'b1;
      out_data_d    = payload;
      out_sop_d     = sop_pend_q;
      out_eop_d     = eop_pend_q;
      out_channel_d = chan_q;
      sop_pend_d    = 1'b0;
      eop_pend_d    = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_DATA;
      sop_pend_q    <= 1'b0;
      eop_pend_q    <= 1'b0;
      chan_q        <= CHANNEL_RESET;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= CHANNEL_RESET;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sop_pend_q    <= sop_pend_d;
      eop_pend_q    <= eop_pend_d;
      chan_q        <= chan_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
    end
  end

  assign st.out_valid         = out_valid_q;
  assign st.out_data          = out_data_q;
  assign st.out_channel       = out_channel_q;
  assign st.out_startofpacket = out_sop_q;
  assign st.out_endofpacket   = out_eop_q;

endmodule

// File: tb/tb_qsys_led_master_0_bytes_to_packets.sv
// ----------------------------------------------------------------------------
// tb_qsys_led_master_0_bytes_to_packets
// Scoreboard bench for the bytes-to-packets decoder. Each payload byte pushes
// its expected beat (data, channel, SOP, EOP, acceptance cycle) when the DUT
// accepts it; a monitor pops and compares every new output beat, checks the
// one-cycle latency and checks that stalled beats are held stable.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_qsys_led_master_0_bytes_to_packets;

  localparam int         CW     = 8;
  localparam logic [7:0] CH_RST = 8'h05;

  typedef struct {
    logic [7:0]    data;
    logic [CW-1:0] ch;
    logic          sop;
    logic          eop;
    int            acc_cyc;
  } beat_t;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  int   cyc;
  beat_t q[$];

  qsys_led_master_0_bytes_to_packets_if #(.CHANNEL_WIDTH(CW)) bus ();

  qsys_led_master_0_bytes_to_packets #(
    .CHANNEL_WIDTH(CW),
    .CHANNEL_RESET(CH_RST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .st   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples one ns before each rising edge.
  logic          held;
  logic [7:0]    h_data;
  logic [CW-1:0] h_ch;
  logic          h_sop, h_eop;
  initial held = 1'b0;

  always begin
    @(negedge clk);
    #4;
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== h_data || bus.out_channel !== h_ch ||
            bus.out_startofpacket !== h_sop || bus.out_endofpacket !== h_eop) begin
          tests_failed++;
          $display("FAIL stall_hold: got v=%b d=%h ch=%h s=%b e=%b, need v=1 d=%h ch=%h s=%b e=%b",
                   bus.out_valid, bus.out_data, bus.out_channel, bus.out_startofpacket,
                   bus.out_endofpacket, h_data, h_ch, h_sop, h_eop);
        end
      end else if (bus.out_valid === 1'b1) begin
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_beat: got d=%h ch=%h s=%b e=%b, need no beat",
                   bus.out_data, bus.out_channel, bus.out_startofpacket, bus.out_endofpacket);
        end else begin
          beat_t e;
          e = q.pop_front();
          if (bus.out_data !== e.data || bus.out_channel !== e.ch ||
              bus.out_startofpacket !== e.sop || bus.out_endofpacket !== e.eop) begin
            tests_failed++;
            $display("FAIL beat: got d=%h ch=%h s=%b e=%b, need d=%h ch=%h s=%b e=%b",
                     bus.out_data, bus.out_channel, bus.out_startofpacket, bus.out_endofpacket,
                     e.data, e.ch, e.sop, e.eop);
          end
          tests_run++;
          if (cyc != e.acc_cyc + 1) begin
            tests_failed++;
            $display("FAIL latency: beat d=%h seen at cycle %0d, need cycle %0d",
                     e.data, cyc, e.acc_cyc + 1);
          end
        end
      end
      held   = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
      h_data = bus.out_data;
      h_ch   = bus.out_channel;
      h_sop  = bus.out_startofpacket;
      h_eop  = bus.out_endofpacket;
    end
  end

  // Drives one byte; returns one ns after the accepting edge. Payload bytes
  // push their expected beat together with the acceptance cycle.
  task automatic send(input logic [7:0] b, input bit pay, input logic [7:0] exp_data,
                      input logic sop, input logic eop, input logic [CW-1:0] ch);
    bit acc;
    int c;
    int waited;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    acc    = 1'b0;
    waited = 0;
    while (!acc && waited < 1000) begin
      @(negedge clk);
      #4;
      acc = (bus.in_ready === 1'b1);
      c   = cyc;
      @(posedge clk);
      #1;
      waited++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: byte %h not accepted, need accept within 1000 cycles", b);
    end else if (pay) begin
      beat_t e;
      e.data = exp_data; e.ch = ch; e.sop = sop; e.eop = eop; e.acc_cyc = c;
      q.push_back(e);
    end
  endtask

  task automatic raw(input logic [7:0] b);
    send(b, 1'b0, 8'h00, 1'b0, 1'b0, '0);
  endtask

  task automatic pay(input logic [7:0] b, input logic [7:0] d, input logic sop,
                     input logic eop, input logic [CW-1:0] ch);
    send(b, 1'b1, d, sop, eop, ch);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #4;
      if (q.size() == 0 && bus.out_valid !== 1'b1) break;
    end
    tests_run++;
    if (q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d beats outstanding, need 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #4;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
        bus.out_startofpacket !== 1'b0 || bus.out_endofpacket !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b d=%h s=%b e=%b, need all 0", bus.out_valid,
               bus.out_data, bus.out_startofpacket, bus.out_endofpacket);
    end
    tests_run++;
    if (bus.out_channel !== CH_RST) begin
      tests_failed++;
      $display("FAIL reset_channel: got %h, need %h", bus.out_channel, CH_RST);
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b, need 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_basic_packet();
    raw(8'h7A); raw(8'h7C); raw(8'h03);
    pay(8'h11, 8'h11, 1'b1, 1'b0, 8'h03);
    pay(8'h22, 8'h22, 1'b0, 1'b0, 8'h03);
    raw(8'h7B);
    pay(8'h33, 8'h33, 1'b0, 1'b1, 8'h03);
    wait_drain();
  endtask

  task automatic test_single_beat_escape();
    raw(8'h7A); raw(8'h7B); raw(8'h7D);
    pay(8'h5A, 8'h7A, 1'b1, 1'b1, 8'h03);
    wait_drain();
  endtask

  task automatic test_channel_escape();
    raw(8'h7C); raw(8'h7D); raw(8'h5C);
    pay(8'h44, 8'h44, 1'b0, 1'b0, 8'h7C);
    raw(8'h7A); raw(8'h7A);
    pay(8'h55, 8'h55, 1'b1, 1'b0, 8'h7C);
    raw(8'h7B);
    pay(8'h66, 8'h66, 1'b0, 1'b1, 8'h7C);
    wait_drain();
  endtask

  task automatic test_back_to_back_stall();
    fork
      begin
        for (int i = 0; i < 8; i++)
          pay(8'h80 + 8'(i), 8'h80 + 8'(i), 1'b0, 1'b0, 8'h7C);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          #4;
          tests_run++;
          if (bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_in_ready: got %b, need 0", bus.in_ready);
          end
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_reset_mid_packet();
    raw(8'h7A); raw(8'h7D);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #4;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_channel !== CH_RST) begin
      tests_failed++;
      $display("FAIL midreset_state: got v=%b ch=%h, need v=0 ch=%h",
               bus.out_valid, bus.out_channel, CH_RST);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    pay(8'h55, 8'h55, 1'b0, 1'b0, CH_RST);
    wait_drain();
  endtask

  function automatic logic [7:0] rand_byte();
    if ($urandom_range(0, 2) == 0) return 8'h7A + 8'($urandom_range(0, 3));
    return 8'($urandom_range(0, 255));
  endfunction

  function automatic bit is_special(input logic [7:0] b);
    return (b >= 8'h7A) && (b <= 8'h7D);
  endfunction

  task automatic test_random_packets();
    logic [7:0] cur_ch;
    bit         done;
    cur_ch = CH_RST;
    done   = 1'b0;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          int len;
          len = $urandom_range(1, 5);
          if ($urandom_range(0, 1) == 1) begin
            cur_ch = rand_byte();
            raw(8'h7C);
            if (is_special(cur_ch)) begin raw(8'h7D); raw(cur_ch ^ 8'h20); end
            else raw(cur_ch);
          end
          raw(8'h7A);
          for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            b = rand_byte();
            if (i == len - 1) raw(8'h7B);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            if (is_special(b)) begin
              raw(8'h7D);
              pay(b ^ 8'h20, b, i == 0, i == len - 1, cur_ch);
            end else begin
              pay(b, b, i == 0, i == len - 1, cur_ch);
            end
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic_packet();
    test_single_beat_escape();
    test_channel_escape();
    test_back_to_back_stall();
    test_reset_mid_packet();
    test_random_packets();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
